// File: rtl/control_ejecucion.sv
// -----------------------------------------------------------------------------
// control_ejecucion
//   Execution controller for the 5-stage MIPS pipeline. Runs the datapath in
//   continuous or single-step mode under debug-unit command, blocks fetch once
//   a HALT is decoded in ID, drains the in-flight instructions and then reports
//   completion. Keeps a saturating count of enabled (executed) cycles.
//
// Parameters
//   W_CICLOS        width of the enabled-cycle counter
//   ETAPAS_DRENADO  enabled cycles spent draining after HALT leaves ID (>= 1)
//
// Ports
//   i_clk             clock, all state changes on the rising edge
//   i_reset           synchronous active-high reset
//   i_start_continuo  pulse: start (IDLE) or switch (PASO) to continuous mode
//   i_start_paso      pulse: start step mode from IDLE
//   i_paso            pulse: advance one cycle in step mode
//   i_halt_ID         instruction in ID is a HALT
//   i_stall_ID        load-use stall, ID is holding
//   i_limpiar         return from TERMINADO to IDLE
//   o_enable          global pipeline enable
//   o_bloquear_fetch  hold PC and load NOP into IF/ID
//   o_terminado       program finished and drained
//   o_ciclos          enabled-cycle count (saturating)
//   o_estado          IDLE=0, CONTINUO=1, PASO=2, DRENANDO=3, TERMINADO=4
// -----------------------------------------------------------------------------
module control_ejecucion #(
  parameter int W_CICLOS       = 32,
  parameter int ETAPAS_DRENADO = 3
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_start_continuo,
  input  logic                i_start_paso,
  input  logic                i_paso,
  input  logic                i_halt_ID,
  input  logic                i_stall_ID,
  input  logic                i_limpiar,
  output logic                o_enable,
  output logic                o_bloquear_fetch,
  output logic                o_terminado,
  output logic [W_CICLOS-1:0] o_ciclos,
  output logic [2:0]          o_estado
);

  localparam int W_DRENADO = $clog2(ETAPAS_DRENADO + 1);
  localparam logic [W_DRENADO-1:0] DRENADO_INI = W_DRENADO'(ETAPAS_DRENADO);
  localparam logic [W_DRENADO-1:0] DRENADO_UNO = W_DRENADO'(1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CONTINUO  = 3'd1,
    PASO      = 3'd2,
    DRENANDO  = 3'd3,
    TERMINADO = 3'd4
  } estado_t;

  estado_t               estado_reg;
  logic                  continuo_reg;
  logic [W_DRENADO-1:0]  drenado_reg;
  logic [W_CICLOS-1:0]   ciclos_reg;

  // A HALT only counts once ID actually hands it on, i.e. not while stalled.
  logic halt_valido;
  logic ciclos_sat;

  assign halt_valido = i_halt_ID & ~i_stall_ID;
  assign ciclos_sat  = &ciclos_reg;

  always_comb begin
    o_enable         = 1'b0;
    o_bloquear_fetch = 1'b0;
    case (estado_reg)
      CONTINUO: begin
        o_enable         = 1'b1;
        o_bloquear_fetch = halt_valido;
      end
      PASO: begin
        o_enable         = i_paso;
        o_bloquear_fetch = halt_valido;
      end
      DRENANDO: begin
        // Draining follows the mode that reached the HALT.
        o_enable         = continuo_reg | i_paso;
        o_bloquear_fetch = 1'b1;
      end
      TERMINADO: begin
        o_bloquear_fetch = 1'b1;
      end
      default: begin
        o_enable         = 1'b0;
        o_bloquear_fetch = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      estado_reg   <= IDLE;
      continuo_reg <= 1'b0;
      drenado_reg  <= '0;
      ciclos_reg   <= '0;
    end else begin
      // Enable is only ever high outside IDLE/TERMINADO, so the counter
      // holds there without extra qualification.
      if (o_enable && !ciclos_sat) begin
        ciclos_reg <= ciclos_reg + W_CICLOS'(1);
      end

      case (estado_reg)
        IDLE: begin
          if (i_start_continuo) begin
            estado_reg   <= CONTINUO;
            continuo_reg <= 1'b1;
            ciclos_reg   <= '0;
          end else if (i_start_paso) begin
            estado_reg   <= PASO;
            continuo_reg <= 1'b0;
            ciclos_reg   <= '0;
          end
        end

        CONTINUO: begin
          if (halt_valido) begin
            estado_reg  <= DRENANDO;
            drenado_reg <= DRENADO_INI;
          end
        end

        PASO: begin
          // A HALT advancing on this step takes precedence over a mode switch:
          // the HALT has already left ID, so draining must start now.
          if (i_paso && halt_valido) begin
            estado_reg  <= DRENANDO;
            drenado_reg <= DRENADO_INI;
          end else if (i_start_continuo) begin
            estado_reg   <= CONTINUO;
            continuo_reg <= 1'b1;
          end
        end

        DRENANDO: begin
          if (o_enable) begin
            drenado_reg <= drenado_reg - DRENADO_UNO;
            if (drenado_reg == DRENADO_UNO) begin
              estado_reg <= TERMINADO;
            end
          end
        end

        TERMINADO: begin
          if (i_limpiar) begin
            estado_reg <= IDLE;
          end
        end

        default: begin
          estado_reg <= IDLE;
        end
      endcase
    end
  end

  assign o_terminado = (estado_reg == TERMINADO);
  assign o_estado    = estado_reg;
  assign o_ciclos    = ciclos_reg;

endmodule

// File: tb/tb_control_ejecucion.sv
// -----------------------------------------------------------------------------
// tb_control_ejecucion
//   Self-checking bench for control_ejecucion. Two instances share the same
//   stimulus: the default 32-bit counter and a 4-bit counter to reach
//   saturation quickly. Outputs are checked every cycle against a behavioural
//   model, plus directed constant checks at the interesting points.
// -----------------------------------------------------------------------------
module tb_control_ejecucion;

  localparam int ETAPAS = 3;

  logic        clk;
  logic        i_reset;
  logic        i_start_continuo;
  logic        i_start_paso;
  logic        i_paso;
  logic        i_halt_ID;
  logic        i_stall_ID;
  logic        i_limpiar;
  logic        o_enable, o_bloquear_fetch, o_terminado;
  logic [31:0] o_ciclos;
  logic [2:0]  o_estado;
  logic        o_enable4, o_bloquear_fetch4, o_terminado4;
  logic [3:0]  o_ciclos4;
  logic [2:0]  o_estado4;

  control_ejecucion #(.W_CICLOS(32), .ETAPAS_DRENADO(ETAPAS)) dut (
    .i_clk(clk), .i_reset(i_reset),
    .i_start_continuo(i_start_continuo), .i_start_paso(i_start_paso),
    .i_paso(i_paso), .i_halt_ID(i_halt_ID), .i_stall_ID(i_stall_ID),
    .i_limpiar(i_limpiar),
    .o_enable(o_enable), .o_bloquear_fetch(o_bloquear_fetch),
    .o_terminado(o_terminado), .o_ciclos(o_ciclos), .o_estado(o_estado)
  );

  control_ejecucion #(.W_CICLOS(4), .ETAPAS_DRENADO(ETAPAS)) dut4 (
    .i_clk(clk), .i_reset(i_reset),
    .i_start_continuo(i_start_continuo), .i_start_paso(i_start_paso),
    .i_paso(i_paso), .i_halt_ID(i_halt_ID), .i_stall_ID(i_stall_ID),
    .i_limpiar(i_limpiar),
    .o_enable(o_enable4), .o_bloquear_fetch(o_bloquear_fetch4),
    .o_terminado(o_terminado4), .o_ciclos(o_ciclos4), .o_estado(o_estado4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: mode as an integer code, drain as "advances remaining".
  int     m_state;   // 0 idle, 1 continuous, 2 step, 3 draining, 4 done
  bit     m_cont;
  int     m_drain;
  longint m_cyc;
  longint m_cyc4;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit m_en(input bit pa);
    case (m_state)
      1:       return 1'b1;
      2:       return pa;
      3:       return m_cont ? 1'b1 : pa;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit m_bl(input bit h, input bit st);
    if (m_state == 3 || m_state == 4) return 1'b1;
    if (m_state == 1 || m_state == 2) return h && !st;
    return 1'b0;
  endfunction

  task automatic m_reset();
    m_state = 0; m_cont = 0; m_drain = 0; m_cyc = 0; m_cyc4 = 0;
  endtask

  task automatic m_step(input bit sc, sp, pa, h, st, li, rs);
    bit en;
    if (rs) begin
      m_reset();
      return;
    end
    en = m_en(pa);
    if (en) begin
      if (m_cyc  < 64'hFFFF_FFFF) m_cyc++;
      if (m_cyc4 < 15)            m_cyc4++;
    end
    case (m_state)
      0: if (sc) begin
           m_state = 1; m_cont = 1; m_cyc = 0; m_cyc4 = 0;
         end else if (sp) begin
           m_state = 2; m_cont = 0; m_cyc = 0; m_cyc4 = 0;
         end
      1: if (h && !st) begin m_state = 3; m_drain = ETAPAS; end
      2: if (pa && h && !st) begin m_state = 3; m_drain = ETAPAS; end
         else if (sc) begin m_state = 1; m_cont = 1; end
      3: if (en) begin
           m_drain--;
           if (m_drain == 0) m_state = 4;
         end
      4: if (li) m_state = 0;
      default: m_state = 0;
    endcase
  endtask

  // One transaction = one clock cycle: drive, check mid-cycle, advance model.
  task automatic tick(input bit sc, sp, pa, h, st, li, rs);
    i_start_continuo = sc; i_start_paso = sp; i_paso = pa;
    i_halt_ID = h; i_stall_ID = st; i_limpiar = li; i_reset = rs;
    #2;
    chk("enable",     o_enable,          m_en(pa));
    chk("bloquear",   o_bloquear_fetch,  m_bl(h, st));
    chk("terminado",  o_terminado,       m_state == 4);
    chk("estado",     o_estado,          m_state);
    chk("ciclos",     o_ciclos,          m_cyc);
    chk("ciclos_w4",  o_ciclos4,         m_cyc4);
    chk("estado_w4",  o_estado4,         m_state);
    $display("t=%0t in sc=%0b sp=%0b pa=%0b h=%0b st=%0b li=%0b rs=%0b | en=%0b bl=%0b est=%0d cyc=%0d cyc4=%0d",
             $time, sc, sp, pa, h, st, li, rs, o_enable, o_bloquear_fetch, o_estado, o_ciclos, o_ciclos4);
    @(posedge clk);
    m_step(sc, sp, pa, h, st, li, rs);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    i_reset = 1'b1; i_start_continuo = 0; i_start_paso = 0; i_paso = 0;
    i_halt_ID = 0; i_stall_ID = 0; i_limpiar = 0;
    @(posedge clk); @(posedge clk); #1;
    m_reset();

    // Reset state, then idle.
    chk("rst_estado", o_estado, 0);
    chk("rst_ciclos", o_ciclos, 0);
    idle(5);

    // Continuous run, HALT ten cycles after the start.
    tick(1, 0, 0, 0, 0, 0, 0);
    idle(10);
    tick(0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < ETAPAS; i++) begin
      chk("drain_estado", o_estado, 3);
      tick(0, 0, 0, 0, 0, 0, 0);
    end
    chk("cont_terminado", o_terminado, 1);
    chk("cont_ciclos", o_ciclos, 14);
    idle(2);
    tick(0, 0, 0, 0, 0, 1, 0);

    // Step mode: pulses two cycles apart, HALT on the 3rd step.
    tick(0, 1, 0, 0, 0, 0, 0);
    for (int p = 1; p <= 6; p++) begin
      tick(0, 0, 1, p == 3, 0, 0, 0);
      tick(0, 0, 0, 0, 0, 0, 0);
    end
    chk("paso_terminado", o_terminado, 1);
    chk("paso_ciclos", o_ciclos, 6);
    tick(0, 0, 0, 0, 0, 1, 0);

    // HALT masked by stall for two cycles in continuous mode.
    tick(1, 0, 0, 0, 0, 0, 0);
    idle(2);
    tick(0, 0, 0, 1, 1, 0, 0);
    tick(0, 0, 0, 1, 1, 0, 0);
    chk("stall_estado", o_estado, 1);
    chk("stall_ciclos", o_ciclos, 4);
    tick(0, 0, 0, 1, 0, 0, 0);
    chk("stall_drain", o_estado, 3);
    idle(4);
    chk("stall_fin_ciclos", o_ciclos, 8);

    // Both starts together; then PASO -> CONTINUO keeps the count.
    tick(0, 0, 0, 0, 0, 0, 1);
    tick(1, 1, 0, 0, 0, 0, 0);
    chk("both_estado", o_estado, 1);
    tick(0, 0, 0, 0, 0, 0, 1);
    tick(0, 1, 0, 0, 0, 0, 0);
    tick(0, 0, 1, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0, 0);
    tick(0, 0, 1, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0, 0, 0);
    chk("switch_estado", o_estado, 1);
    chk("switch_ciclos", o_ciclos, 2);

    // Saturation of the 4-bit counter, then reset in mid-drain.
    tick(0, 0, 0, 0, 0, 0, 1);
    tick(1, 0, 0, 0, 0, 0, 0);
    idle(20);
    chk("sat_ciclos4", o_ciclos4, 15);
    chk("sat_ciclos32", o_ciclos, 20);
    tick(0, 0, 0, 1, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0, 1);
    chk("mid_rst_estado", o_estado, 0);
    chk("mid_rst_ciclos", o_ciclos, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      tick($urandom_range(0, 11) == 0, $urandom_range(0, 11) == 0,
           $urandom_range(0, 1) == 0,  $urandom_range(0, 7) == 0,
           $urandom_range(0, 3) == 0,  $urandom_range(0, 5) == 0,
           $urandom_range(0, 79) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
